// File: rtl/fc_out_argmax.sv
// Argmax stage for the folded FC output layer.
// Snapshots the output feature map on start, scans LANE entries per cycle, and presents max/index on valid/ready.
module fc_out_argmax #(
  parameter  int unsigned IDIM  = 256,
  parameter  int unsigned IWID  = 10,
  parameter  int unsigned LANE  = 4,
  localparam int unsigned NBEAT = IDIM / LANE,
  localparam int unsigned XWID  = (IDIM > 1) ? $clog2(IDIM) : 1,
  localparam int unsigned CWID  = (NBEAT > 1) ? $clog2(NBEAT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IDIM*IWID-1:0] iFmap,
  output logic                 busy,
  output logic                 oValid,
  input  logic                 oReady,
  output logic [XWID-1:0]      oIdx,
  output logic [IWID-1:0]      oMax
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t          state;
  state_t          state_nx;
  logic [CWID-1:0] cnt;
  logic [IWID-1:0] run_max;
  logic [XWID-1:0] run_idx;
  logic [IWID-1:0] lane_max;
  logic [XWID-1:0] lane_idx;
  logic [XWID-1:0] cand_idx;
  logic [IWID-1:0] snap [IDIM];
  logic            take;
  logic            last_beat;

  assign take      = (state == IDLE) && start;
  assign last_beat = (cnt == CWID'(NBEAT - 1));

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)     state_nx = SCAN;
      SCAN:    if (last_beat) state_nx = HOLD;
      HOLD:    if (oReady)    state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Lanes visited in ascending index with strict compare, so ties keep the lowest index.
  always_comb begin
    lane_max = run_max;
    lane_idx = run_idx;
    cand_idx = '0;
    for (int k = 0; k < LANE; k++) begin
      cand_idx = XWID'(cnt) * XWID'(LANE) + XWID'(k);
      if (snap[cand_idx] > lane_max) begin
        lane_max = snap[cand_idx];
        lane_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      run_max <= '0;
      run_idx <= '0;
      oIdx    <= '0;
      oMax    <= '0;
      busy    <= 1'b0;
      oValid  <= 1'b0;
    end else begin
      state  <= state_nx;
      busy   <= (state_nx != IDLE);
      oValid <= (state_nx == HOLD);
      if (take) begin
        cnt     <= '0;
        run_max <= '0;
        run_idx <= '0;
      end else if (state == SCAN) begin
        run_max <= lane_max;
        run_idx <= lane_idx;
        if (last_beat) begin
          oIdx <= lane_idx;
          oMax <= lane_max;
        end else begin
          cnt <= cnt + CWID'(1);
        end
      end
    end
  end

  // Snapshot buffer carries no reset; it is fully rewritten on every accepted start.
  always_ff @(posedge clk) begin
    if (rst_n && take) begin
      for (int i = 0; i < IDIM; i++) begin
        snap[i] <= iFmap[i*IWID +: IWID];
      end
    end
  end

endmodule

// File: tb/tb_fc_out_argmax.sv
// Directed bench for fc_out_argmax with a queue scoreboard of expected results.
module tb_fc_out_argmax;

  localparam int unsigned IDIM  = 256;
  localparam int unsigned IWID  = 10;
  localparam int unsigned LANE  = 4;
  localparam int unsigned NBEAT = IDIM / LANE;
  localparam int unsigned XWID  = 8;

  typedef struct packed {
    logic [XWID-1:0] idx;
    logic [IWID-1:0] mx;
  } res_t;

  logic                 clk    = 1'b0;
  logic                 rst_n  = 1'b0;
  logic                 start  = 1'b0;
  logic                 oReady = 1'b0;
  logic [IDIM*IWID-1:0] fmap   = '0;
  logic                 busy;
  logic                 oValid;
  logic [XWID-1:0]      oIdx;
  logic [IWID-1:0]      oMax;

  int   n_chk  = 0;
  int   n_fail = 0;
  res_t sb[$];

  fc_out_argmax #(.IDIM(IDIM), .IWID(IWID), .LANE(LANE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .iFmap  (fmap),
    .busy   (busy),
    .oValid (oValid),
    .oReady (oReady),
    .oIdx   (oIdx),
    .oMax   (oMax)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [IDIM*IWID-1:0] m);
    res_t            r;
    logic [IWID-1:0] v;
    r = '0;
    for (int i = 0; i < IDIM; i++) begin
      v = m[i*IWID +: IWID];
      if (v > r.mx) begin
        r.mx  = v;
        r.idx = XWID'(i);
      end
    end
    return r;
  endfunction

  task automatic rand_map();
    for (int i = 0; i < IDIM; i++) fmap[i*IWID +: IWID] = IWID'($urandom);
  endtask

  task automatic launch(input res_t e);
    start = 1'b1;
    sb.push_back(e);
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for oValid; optionally scrambles iFmap and pulses start meanwhile.
  task automatic wait_valid(input bit scramble);
    int lat;
    lat = 0;
    while (oValid !== 1'b1 && lat < 4 * NBEAT) begin
      if (scramble) begin
        rand_map();
        start = 1'($urandom);
      end
      step();
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(NBEAT));
  endtask

  task automatic check_result(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(oValid), 32'd1);
      chk({tag, "_idx"}, 32'(oIdx), 32'(e.idx));
      chk({tag, "_max"}, 32'(oMax), 32'(e.mx));
    end
  endtask

  task automatic handshake(input bit st);
    oReady = 1'b1;
    start  = st;
    step();
    oReady = 1'b0;
    start  = 1'b0;
    chk("hs_valid_low", 32'(oValid), 32'd0);
    chk("hs_busy_low", 32'(busy), 32'd0);
    step();
    chk("hs_idle_stays", 32'(busy), 32'd0);
  endtask

  initial begin
    res_t e;
    int   nres;

    // 1: reset then idle
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(oValid), 32'd0);
      chk("rst_idx", 32'(oIdx), 32'd0);
      chk("rst_max", 32'(oMax), 32'd0);
    end

    // 2: ramp map, max at the last index
    for (int i = 0; i < IDIM; i++) fmap[i*IWID +: IWID] = IWID'(i % 1024);
    e.idx = 8'd255;
    e.mx  = 10'd255;
    launch(e);
    chk("ramp_busy", 32'(busy), 32'd1);
    chk("ramp_novalid", 32'(oValid), 32'd0);
    wait_valid(1'b0);
    check_result("ramp");
    handshake(1'b0);

    // 3: tie between index 37 and 200
    fmap = '0;
    fmap[37*IWID +: IWID]  = 10'd1023;
    fmap[200*IWID +: IWID] = 10'd1023;
    e.idx = 8'd37;
    e.mx  = 10'd1023;
    launch(e);
    wait_valid(1'b0);
    check_result("tie");
    handshake(1'b0);

    // 4: map changes during scan, start pulses ignored, result held until oReady
    rand_map();
    launch(model(fmap));
    wait_valid(1'b1);
    e = sb[0];
    for (int c = 0; c < 20; c++) begin
      start = 1'($urandom);
      rand_map();
      step();
      chk("hold_valid", 32'(oValid), 32'd1);
      chk("hold_idx", 32'(oIdx), 32'(e.idx));
      chk("hold_max", 32'(oMax), 32'(e.mx));
    end
    start = 1'b0;
    check_result("snap");
    handshake(1'b1);

    // 5: reset mid-scan aborts, then a fresh search completes
    rand_map();
    launch(model(fmap));
    repeat (30) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    void'(sb.pop_back());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(oValid), 32'd0);
    chk("abort_idx", 32'(oIdx), 32'd0);
    chk("abort_max", 32'(oMax), 32'd0);
    for (int c = 0; c < NBEAT + 4; c++) begin
      step();
      chk("abort_no_valid", 32'(oValid), 32'd0);
    end
    rand_map();
    launch(model(fmap));
    wait_valid(1'b0);
    check_result("fresh");
    handshake(1'b0);

    // 6: start and oReady held high, one result every NBEAT+2 cycles
    nres   = 0;
    oReady = 1'b1;
    start  = 1'b1;
    for (int c = 0; c < 3 * (NBEAT + 2); c++) begin
      rand_map();
      if (c % (NBEAT + 2) == 0) sb.push_back(model(fmap));
      step();
      if (oValid === 1'b1) begin
        chk("b2b_phase", 32'(c % (NBEAT + 2)), 32'(NBEAT));
        check_result("b2b");
        nres++;
      end
    end
    start  = 1'b0;
    oReady = 1'b0;
    chk("b2b_count", 32'(nres), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
